// File: rtl/fir_stream_mc.sv
// Multi-channel streaming FIR: one multiply-accumulate per cycle over TAPS taps,
// per-channel delay lines, programmable coefficient banks, rounded/saturated output.
module fir_stream_mc #(
   parameter int DATA_WIDTH = 12,
   parameter int COEF_WIDTH = 12,
   parameter int TAPS       = 16,
   parameter int CHANNELS   = 2,
   parameter int BANKS      = 4,
   parameter int OUT_SHIFT  = 12
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               s_valid,
   output logic                                               s_ready,
   input  logic [DATA_WIDTH-1:0]                              s_data,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] s_chan,
   input  logic [$clog2(BANKS)-1:0]                           bank_sel,
   output logic                                               m_valid,
   input  logic                                               m_ready,
   output logic [DATA_WIDTH-1:0]                              m_data,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] m_chan,
   output logic                                               m_sat,
   input  logic                                               coef_we,
   input  logic [$clog2(BANKS)-1:0]                           coef_bank,
   input  logic [$clog2(TAPS)-1:0]                            coef_addr,
   input  logic [COEF_WIDTH-1:0]                              coef_data,
   output logic                                               coef_ready,
   input  logic                                               flush
);

   localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int BW  = $clog2(BANKS);
   localparam int TAW = $clog2(TAPS);
   localparam int TCW = TAW + 1;
   localparam int PW  = DATA_WIDTH + COEF_WIDTH;
   localparam int AW  = PW + TAW;

   localparam logic signed [AW:0] ROUND   = (AW+1)'(1) << (OUT_SHIFT - 1);
   localparam logic signed [AW:0] SAT_MAX = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AW:0] SAT_MIN = {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_OUT
   } state_t;

   state_t state_q, state_d;

   logic signed [DATA_WIDTH-1:0] dl_q   [CHANNELS][TAPS];
   logic signed [COEF_WIDTH-1:0] coef_q [BANKS][TAPS];

   logic [CHW-1:0]        chan_q;
   logic [BW-1:0]         bank_q;
   logic [TCW-1:0]        tap_q;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic signed [PW-1:0]  prod;
   logic signed [AW:0]    rnd_sum, shifted;

   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [CHW-1:0]        m_chan_q;
   logic                  m_sat_q, m_sat_d;

   logic idle, mac_done, chan_ok, addr_ok, accept, clear_lines, coef_wr;

   // Range guards collapse to constants when the index space is fully populated.
   generate
      if (CHANNELS == (1 << CHW)) begin : g_chan_full
         assign chan_ok = 1'b1;
      end else begin : g_chan_part
         assign chan_ok = (s_chan < CHW'(CHANNELS));
      end
      if (TAPS == (1 << TAW)) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_part
         assign addr_ok = (coef_addr < TAW'(TAPS));
      end
   endgenerate

   assign idle        = (state_q == ST_IDLE);
   assign mac_done    = (tap_q == TCW'(TAPS));
   assign clear_lines = idle && flush;
   assign accept      = idle && s_valid && !flush && chan_ok;
   assign coef_wr     = idle && coef_we && addr_ok;

   assign s_ready    = idle;
   assign coef_ready = idle;
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_chan     = m_chan_q;
   assign m_sat      = m_sat_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)   state_d = ST_MAC;
         ST_MAC:  if (mac_done) state_d = ST_OUT;
         ST_OUT:  if (m_ready)  state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      prod    = dl_q[chan_q][tap_q[TAW-1:0]] * coef_q[bank_q][tap_q[TAW-1:0]];
      acc_d   = acc_q + AW'(prod);
      rnd_sum = {acc_q[AW-1], acc_q} + ROUND;
      shifted = rnd_sum >>> OUT_SHIFT;
      m_sat_d = 1'b1;
      if (shifted > SAT_MAX) begin
         m_data_d = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         m_data_d = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         m_data_d = shifted[DATA_WIDTH-1:0];
         m_sat_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         tap_q     <= '0;
         chan_q    <= '0;
         bank_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_chan_q  <= '0;
         m_sat_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  acc_q  <= '0;
                  tap_q  <= '0;
                  chan_q <= s_chan;
                  bank_q <= bank_sel;
               end
            end
            ST_MAC: begin
               if (!mac_done) begin
                  acc_q <= acc_d;
                  tap_q <= tap_q + TCW'(1);
               end else begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= m_data_d;
                  m_chan_q  <= chan_q;
                  m_sat_q   <= m_sat_d;
               end
            end
            ST_OUT: begin
               if (m_ready) m_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Flush wins over a same-cycle sample, which is then dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++)
               dl_q[c][k] <= '0;
      end else if (clear_lines) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++)
               dl_q[c][k] <= '0;
      end else if (accept) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (s_chan == CHW'(c)) begin
               for (int k = TAPS - 1; k > 0; k--)
                  dl_q[c][k] <= dl_q[c][k-1];
               dl_q[c][0] <= s_data;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < BANKS; b++)
            for (int k = 0; k < TAPS; k++)
               coef_q[b][k] <= '0;
      end else if (coef_wr) begin
         coef_q[coef_bank][coef_addr] <= coef_data;
      end
   end

endmodule

// File: tb/tb_fir_stream_mc.sv
// Bench for fir_stream_mc: table vectors and a reference model feed a scoreboard
// that is drained by an output monitor.
module tb_fir_stream_mc;

   logic               clk = 1'b0;
   logic               reset;
   logic               s_valid, s_ready;
   logic [11:0]        s_data;
   logic               s_chan;
   logic [1:0]         bank_sel;
   logic               m_valid, m_ready;
   logic signed [11:0] m_data;
   logic               m_chan, m_sat;
   logic               coef_we;
   logic [1:0]         coef_bank;
   logic [3:0]         coef_addr;
   logic [11:0]        coef_data;
   logic               coef_ready;
   logic               flush;

   typedef struct {
      int data;
      int chan;
      int sat;
   } exp_t;

   typedef struct {
      int data;
      int chan;
      int bank;
      int exp_data;
      int exp_sat;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[21];
   int   mdl_dl[2][16];
   int   mdl_h[4][16];
   int   acc_cyc = 0;
   bit   lat_pending = 0;
   bit   mv_prev = 0;
   int   last_out[2];

   fir_stream_mc dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan), .bank_sel(bank_sel),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_sat(m_sat),
      .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_ready(coef_ready), .flush(flush)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Output monitor: latency on each rising m_valid, scoreboard pop on handshake.
   always @(negedge clk) begin
      if (reset) begin
         mv_prev = 0;
      end else begin
         if (m_valid && !mv_prev && lat_pending) begin
            chk("latency", cyc - acc_cyc, 17);
            lat_pending = 0;
         end
         mv_prev = m_valid;
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got data %0d chan %0d, expected none", m_data, m_chan);
            end else begin
               mon_e = sb_q.pop_front();
               chk("m_data", m_data, mon_e.data);
               chk("m_chan", m_chan, mon_e.chan);
               chk("m_sat", m_sat, mon_e.sat);
               $display("out chan=%0d data=%0d sat=%0d", m_chan, m_data, m_sat);
            end
            last_out[m_chan] = m_data;
         end
      end
   end

   task automatic model_push(input int chan, input int bank);
      longint acc;
      longint r;
      exp_t   e;
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(mdl_dl[chan][k]) * longint'(mdl_h[bank][k]);
      r = (acc + 2048) >>> 12;
      e.chan = chan;
      if (r > 2047) begin
         e.data = 2047; e.sat = 1;
      end else if (r < -2048) begin
         e.data = -2048; e.sat = 1;
      end else begin
         e.data = int'(r); e.sat = 0;
      end
      sb_q.push_back(e);
   endtask

   task automatic send(input int data, input int chan, input int bank,
                       input bit use_tab, input int tdata, input int tsat);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL s_ready_timeout: got 0, expected 1");
         return;
      end
      s_valid  = 1'b1;
      s_data   = 12'(data);
      s_chan   = 1'(chan);
      bank_sel = 2'(bank);
      for (int k = 15; k > 0; k--) mdl_dl[chan][k] = mdl_dl[chan][k-1];
      mdl_dl[chan][0] = data;
      if (use_tab) begin
         e.data = tdata; e.chan = chan; e.sat = tsat;
         sb_q.push_back(e);
      end else begin
         model_push(chan, bank);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      acc_cyc = cyc;
      lat_pending = 1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((sb_q.size() != 0 || !s_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got %0d pending, expected 0", sb_q.size());
      end
   endtask

   task automatic write_coef(input int bank, input int addr, input int data, input bit take);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_bank = 2'(bank);
      coef_addr = 4'(addr);
      coef_data = 12'(data);
      if (take) mdl_h[bank][addr] = data;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 16; k++) mdl_dl[c][k] = 0;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   initial begin
      int n;
      int mv_cnt;
      reset = 1'b1; s_valid = 0; s_data = '0; s_chan = 0; bank_sel = '0;
      m_ready = 1'b1; coef_we = 0; coef_bank = '0; coef_addr = '0; coef_data = '0; flush = 0;
      for (int c = 0; c < 2; c++) begin
         last_out[c] = 0;
         for (int k = 0; k < 16; k++) mdl_dl[c][k] = 0;
      end
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 16; k++) mdl_h[b][k] = 0;

      for (int k = 0; k < 16; k++) vecs[k] = '{(k == 0) ? -2048 : 0, 0, 0, k + 1, 0};
      vecs[16] = '{1024, 0, 2, 1, 0};
      vecs[17] = '{1023, 0, 2, 0, 0};
      vecs[18] = '{-1024, 0, 2, 0, 0};
      vecs[19] = '{-1025, 0, 2, -1, 0};
      vecs[20] = '{2047, 0, 2, 1, 0};

      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_chan", m_chan, 0);
      chk("rst_m_sat", m_sat, 0);
      chk("rst_coef_ready", coef_ready, 1);
      reset = 1'b0;

      // Impulse: h[k] = -2(k+1), x = -2048 gives exactly k+1 per output.
      for (int k = 0; k < 16; k++) write_coef(0, k, -2 * (k + 1), 1);
      for (int i = 0; i < 16; i++)
         send(vecs[i].data, vecs[i].chan, vecs[i].bank, 1, vecs[i].exp_data, vecs[i].exp_sat);
      wait_idle();

      // Saturation, both polarities.
      for (int k = 0; k < 16; k++) write_coef(1, k, 2047, 1);
      for (int i = 0; i < 16; i++) send(2047, 1, 1, 0, 0, 0);
      wait_idle();
      chk("sat_pos_final", last_out[1], 2047);
      do_flush();
      for (int i = 0; i < 16; i++) send(-2048, 1, 1, 0, 0, 0);
      wait_idle();
      chk("sat_neg_final", last_out[1], -2048);

      // Rounding around the half-LSB point.
      write_coef(2, 0, 2, 1);
      do_flush();
      for (int i = 16; i < 21; i++)
         send(vecs[i].data, vecs[i].chan, vecs[i].bank, 1, vecs[i].exp_data, vecs[i].exp_sat);
      wait_idle();

      // Channel isolation with identical coefficients and opposite inputs.
      for (int k = 0; k < 16; k++) write_coef(3, k, 3, 1);
      do_flush();
      for (int p = 0; p < 6; p++) begin
         send(1000, 0, 3, 0, 0, 0);
         send(-1000, 1, 3, 0, 0, 0);
         wait_idle();
         chk("isolation_negation", last_out[1], -last_out[0]);
      end

      // Backpressure: output holds for 10 cycles, coefficient write ignored.
      do_flush();
      m_ready = 1'b0;
      send(-2048, 0, 0, 0, 0, 0);
      n = 0;
      while (!m_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_mvalid_rise", m_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) begin
            coef_we = 1'b1; coef_bank = 2'd0; coef_addr = 4'd0; coef_data = 12'd100;
         end
         if (i == 3) coef_we = 1'b0;
         chk("bp_hold_valid", m_valid, 1);
         chk("bp_hold_data", m_data, 1);
         chk("bp_hold_chan", m_chan, 0);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_coef_ready", coef_ready, 0);
      end
      coef_we = 1'b0;
      m_ready = 1'b1;
      wait_idle();
      do_flush();
      send(-2048, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0);
      wait_idle();

      // Reset during MAC clears everything, including coefficients.
      send(-2048, 0, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_s_ready", s_ready, 1);
      chk("midrst_coef_ready", coef_ready, 1);
      sb_q.delete();
      lat_pending = 0;
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 16; k++) mdl_dl[c][k] = 0;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 16; k++) mdl_h[b][k] = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      send(-2048, 0, 0, 0, 0, 0);
      wait_idle();
      chk("post_reset_zero", last_out[0], 0);

      // Flush coinciding with a sample: sample dropped, history cleared.
      write_coef(0, 0, -2, 1);
      write_coef(0, 1, -4, 1);
      @(negedge clk);
      flush = 1'b1; s_valid = 1'b1; s_data = 12'd700; s_chan = 1'b0; bank_sel = 2'd0;
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 16; k++) mdl_dl[c][k] = 0;
      @(posedge clk);
      #1;
      flush = 1'b0; s_valid = 1'b0;
      mv_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid) mv_cnt++;
      end
      chk("flush_no_output", mv_cnt, 0);
      send(-2048, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0);
      wait_idle();

      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
